instruction_loader: RTL
=======================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter SIZE, default 64, instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default $clog2(SIZE), word address width.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 word_cnt  input  ADDR_W+1  number of words to load; sampled with start.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  byte-stream ready.
REQ-010 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-011 mem_a  output  ADDR_W  instruction memory word address.
REQ-012 mem_wd  output  32  instruction memory write data.
REQ-013 busy  output  1  high while a session is in progress.
REQ-014 done  output  1  high in DONE.
REQ-015 cpu_hold  output  1  keeps the CPU in reset while the program image is invalid.
REQ-016 err  output  1  checksum mismatch flag; tied 0 when the checksum feature is compiled out.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD, CHECK (checksum build only) and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL latch eff_cnt = min(word_cnt, SIZE), clear the word index, byte index, accumulator and err, and enter LOAD; if eff_cnt==0, it SHALL enter DONE (or CHECK in the checksum build) instead.
REQ-019 start in LOAD or CHECK SHALL be ignored.
REQ-020 in_ready SHALL be 1 exactly in LOAD and CHECK; a byte is accepted when in_valid && in_ready.
REQ-021 Accepted bytes SHALL be assembled little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-022 In the cycle after the 4th byte of a word is accepted, mem_we SHALL be 1 for exactly one cycle, with mem_a = word index and mem_wd = the assembled word.
REQ-023 Byte acceptance SHALL continue in the mem_we cycle; with in_valid held high, the sustained rate SHALL be one word per 4 cycles.
REQ-024 mem_a SHALL count 0..eff_cnt-1 and never reach SIZE.
REQ-025 After the 4th byte of word eff_cnt-1 is accepted, the state SHALL move to DONE (or CHECK); the final mem_we cycle SHALL still occur.
REQ-026 busy SHALL be 1 in LOAD and CHECK; done SHALL be 1 in DONE until the next start.
REQ-027 cpu_hold SHALL be 1 in every state except DONE.
REQ-028 mem_we SHALL be 0 in every cycle other than those defined in REQ-022.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_a=0, mem_wd=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-030 Reset during LOAD SHALL discard any partial word and SHALL issue no write.

Configuration
REQ-031 With the macro INSTRUCTION_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all accepted data bytes, accept one extra byte in CHECK, set err=1 on mismatch, and then enter DONE.
REQ-032 With the checksum build, err SHALL be held until the next start or reset, and done SHALL assert regardless of err.
REQ-033 Without INSTRUCTION_LOADER_CHECKSUM_EN, the block SHALL have no CHECK state, err SHALL be constant 0, and LOAD SHALL go directly to DONE.

Verification
REQ-034 Reset, then start with word_cnt=2, and bytes 13 00 00 00 93 00 10 00 with in_valid held -> two writes: mem_a=0/mem_wd=0x00000013, then mem_a=1/mem_wd=0x00100093; done=1; cpu_hold=0.
REQ-035 word_cnt=100 with SIZE=64 -> exactly 64 writes, addresses 0..63, no write at address 64.
REQ-036 in_valid toggling every other cycle, word_cnt=1, bytes EF BE AD DE -> a single write of 0xDEADBEEF one cycle after the 4th handshake.
REQ-037 rst pulsed after 2 bytes of word 0 -> no mem_we, state IDLE, cpu_hold=1; a restarted session then loads correctly.
REQ-038 Checksum build, word_cnt=1, bytes 01 02 03 04 then 04 -> err=0; repeating with a final byte of 05 -> err=1 and done=1.
REQ-039 word_cnt=0 -> DONE on the next cycle (CHECK in the checksum build) with no writes; start asserted in LOAD -> session unaffected.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int SIZE   = 64,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              err
);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
    localparam state_t POST_LOAD = CHECK;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam state_t POST_LOAD = DONE;
`endif

    localparam logic [ADDR_W:0] SIZE_V = (ADDR_W+1)'(SIZE);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   eff_cnt;
    logic [ADDR_W:0]   eff_nxt;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       acc;
    logic              accept;
    logic              start_ok;
    logic              word_end;
    logic              last_word;

    assign eff_nxt   = (word_cnt > SIZE_V) ? SIZE_V : word_cnt;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign accept    = in_valid && in_ready;
    assign word_end  = accept && (state == LOAD) && (byte_idx == 2'd3);
    // eff_cnt >= 1 whenever LOAD is entered, so the subtraction never underflows here
    assign last_word = ({1'b0, word_idx} == eff_cnt - (ADDR_W+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = (eff_nxt == '0) ? POST_LOAD : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (word_end && last_word) state_nxt = POST_LOAD;
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = DONE;
            end
`endif
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nxt = (eff_nxt == '0) ? POST_LOAD : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eff_cnt  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            acc      <= '0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_wd   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                eff_cnt  <= eff_nxt;
                word_idx <= '0;
                byte_idx <= '0;
                acc      <= '0;
            end else if (accept && state == LOAD) begin
                if (byte_idx == 2'd3) begin
                    mem_we   <= 1'b1;
                    mem_a    <= word_idx;
                    mem_wd   <= {in_data, acc};
                    word_idx <= word_idx + ADDR_W'(1);
                    byte_idx <= 2'd0;
                end else begin
                    case (byte_idx)
                        2'd0:    acc[7:0]   <= in_data;
                        2'd1:    acc[15:8]  <= in_data;
                        default: acc[23:16] <= in_data;
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (start_ok) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (accept && state == LOAD) begin
            csum <= csum ^ in_data;
        end else if (accept && state == CHECK) begin
            err <= (in_data != csum);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
